dst_data_fifo: RTL and testbench

//  Parametrised destination data buffer for the blitter read-modify-write path.

---
 rtl/dst_data_fifo.sv | 143 ++++++++++++++
 tb/tb_dst_data_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dst_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dst_data_fifo
// Purpose  : Destination data buffer for the blitter read-modify-write path.
//            Builds WIDTH-bit words from successive 8-bit ID bus loads
//            (little-endian, lane 0 first), queues them in a DEPTH-entry
//            FIFO and presents the head word to the ALU/write stage.
// Ports    : MasterClock  - system clock, all state on rising edge
//            RESET        - synchronous active-high reset
//            LDDSTL       - active-low byte load strobe (one byte per low cycle)
//            ID           - internal data bus byte
//            FLUSH        - synchronous clear of FIFO, assembly and overrun
//            DSTD_POP     - consume head word
//            DSTD         - head word
//            DSTD_VALID   - FIFO non-empty
//            DSTD_FULL    - FIFO holds DEPTH words
//            DSTD_LEVEL   - number of stored words
//            DSTD_OVERRUN - sticky, a completed word was dropped
// Options  : DSTD_HOLD_EN - when defined, DSTD holds the last popped word while
//            the FIFO is empty (cleared by RESET only); otherwise DSTD is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dst_data_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       MasterClock,
  input  logic                       RESET,
  input  logic                       LDDSTL,
  input  logic [7:0]                 ID,
  input  logic                       FLUSH,
  input  logic                       DSTD_POP,
  output logic [WIDTH-1:0]           DSTD,
  output logic                       DSTD_VALID,
  output logic                       DSTD_FULL,
  output logic [$clog2(DEPTH+1)-1:0] DSTD_LEVEL,
  output logic                       DSTD_OVERRUN
);

  localparam int BYTES = WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_LANE = BW'(BYTES - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_next;
  logic [BW-1:0]    bcnt;
  logic [WIDTH-1:0] asm_word;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] idle_word;
  logic             overrun;

  logic load;
  logic push_req;
  logic push_ok;
  logic pop_ok;

  assign load     = ~LDDSTL;
  assign push_req = load && (bcnt == LAST_LANE);
  // Pop only counts when something is stored at cycle start; a pop on a full
  // FIFO frees the slot that a simultaneous completing load then fills.
  assign pop_ok   = DSTD_POP && (level != '0);
  assign push_ok  = push_req && ((level != LVL_FULL) || pop_ok);

  // Assembly register with the current byte merged in: this is both the next
  // assembly value and, on the last lane, the completed word pushed this edge.
  always_comb begin
    word = asm_word;
    word[int'(bcnt)*8 +: 8] = ID;
  end

  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok) begin
      level_next = level + LW'(1);
    end else if (!push_ok && pop_ok) begin
      level_next = level - LW'(1);
    end
  end

  always_ff @(posedge MasterClock) begin
    if (RESET || FLUSH) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      bcnt     <= '0;
      asm_word <= '0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        asm_word <= word;
        bcnt     <= (bcnt == LAST_LANE) ? '0 : bcnt + BW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      if (push_req && !push_ok) begin
        overrun <= 1'b1;
      end
    end
  end

  // Storage array is not reset; entries are only observable once written.
  always_ff @(posedge MasterClock) begin
    if (!RESET && !FLUSH && push_ok) begin
      mem[wr_ptr] <= word;
    end
  end

`ifdef DSTD_HOLD_EN
  logic [WIDTH-1:0] hold_word;

  // FLUSH deliberately leaves the hold value alone; it still blocks the pop.
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      hold_word <= '0;
    end else if (!FLUSH && pop_ok) begin
      hold_word <= mem[rd_ptr];
    end
  end

  assign idle_word = hold_word;
`else
  assign idle_word = '0;
`endif

  assign DSTD_VALID   = (level != '0);
  assign DSTD_FULL    = (level == LVL_FULL);
  assign DSTD_LEVEL   = level;
  assign DSTD_OVERRUN = overrun;
  assign DSTD         = DSTD_VALID ? mem[rd_ptr] : idle_word;

endmodule
`default_nettype wire

// File: tb/tb_dst_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dst_data_fifo
// Purpose  : Self-checking bench for dst_data_fifo (WIDTH=16, DEPTH=4).
//            Directed scenarios followed by random traffic, all checked
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dst_data_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int BYTES = WIDTH / 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             MasterClock = 1'b0;
  logic             RESET       = 1'b1;
  logic             LDDSTL      = 1'b1;
  logic [7:0]       ID          = 8'h00;
  logic             FLUSH       = 1'b0;
  logic             DSTD_POP    = 1'b0;
  logic [WIDTH-1:0] DSTD;
  logic             DSTD_VALID;
  logic             DSTD_FULL;
  logic [LW-1:0]    DSTD_LEVEL;
  logic             DSTD_OVERRUN;

  dst_data_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .MasterClock (MasterClock),
    .RESET       (RESET),
    .LDDSTL      (LDDSTL),
    .ID          (ID),
    .FLUSH       (FLUSH),
    .DSTD_POP    (DSTD_POP),
    .DSTD        (DSTD),
    .DSTD_VALID  (DSTD_VALID),
    .DSTD_FULL   (DSTD_FULL),
    .DSTD_LEVEL  (DSTD_LEVEL),
    .DSTD_OVERRUN(DSTD_OVERRUN)
  );

  always #5 MasterClock = ~MasterClock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [7:0]       lanes [BYTES];
  int               m_bcnt    = 0;
  bit               m_overrun = 1'b0;
  logic [WIDTH-1:0] m_hold    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_dstd();
    if (q.size() > 0) return q[0];
`ifdef DSTD_HOLD_EN
    return m_hold;
`else
    return '0;
`endif
  endfunction

  task automatic model_clear(input bit is_reset);
    q.delete();
    m_bcnt    = 0;
    m_overrun = 1'b0;
    for (int i = 0; i < BYTES; i++) lanes[i] = 8'h00;
    if (is_reset) m_hold = '0;
  endtask

  task automatic model_step(input bit ld_n, input logic [7:0] id, input bit fl,
                            input bit pp, input bit rs);
    bit               was_full;
    bit               popped;
    bit               complete;
    logic [WIDTH-1:0] w;
    if (rs) begin
      model_clear(1'b1);
    end else if (fl) begin
      model_clear(1'b0);
    end else begin
      was_full = (q.size() == DEPTH);
      popped   = pp && (q.size() > 0);
      complete = 1'b0;
      w        = '0;
      if (!ld_n) begin
        lanes[m_bcnt] = id;
        if (m_bcnt == BYTES - 1) begin
          complete = 1'b1;
          for (int i = 0; i < BYTES; i++) w[i*8 +: 8] = lanes[i];
          m_bcnt = 0;
        end else begin
          m_bcnt++;
        end
      end
      if (popped) begin
        m_hold = q[0];
        void'(q.pop_front());
      end
      if (complete) begin
        if (!was_full || popped) q.push_back(w);
        else m_overrun = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_dstd"},    32'(DSTD),         32'(exp_dstd()));
    check({tag, "_valid"},   32'(DSTD_VALID),   32'(q.size() != 0));
    check({tag, "_full"},    32'(DSTD_FULL),    32'(q.size() == DEPTH));
    check({tag, "_level"},   32'(DSTD_LEVEL),   32'(q.size()));
    check({tag, "_overrun"}, 32'(DSTD_OVERRUN), 32'(m_overrun));
  endtask

  // Called just after a falling edge: drive, clock, update model, compare.
  task automatic step(input bit ld_n, input logic [7:0] id, input bit fl,
                      input bit pp, input bit rs, input string tag);
    LDDSTL   = ld_n;
    ID       = id;
    FLUSH    = fl;
    DSTD_POP = pp;
    RESET    = rs;
    @(posedge MasterClock);
    model_step(ld_n, id, fl, pp, rs);
    @(negedge MasterClock);
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic pop1(input string tag);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic push_word(input logic [15:0] w, input string tag);
    step(1'b0, w[7:0],  1'b0, 1'b0, 1'b0, tag);
    step(1'b0, w[15:8], 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [15:0] seq [4];
    seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333; seq[3] = 16'h4444;
    model_clear(1'b1);
    @(negedge MasterClock);

    // 1: reset state
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "rst");
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "rst");
    check("rst_dstd_const",  32'(DSTD), 32'h0);
    check("rst_level_const", 32'(DSTD_LEVEL), 32'h0);

    // 2: first word assembly, visible the cycle after completion
    step(1'b0, 8'h34, 1'b0, 1'b0, 1'b0, "t2a");
    check("t2_not_yet_valid", 32'(DSTD_VALID), 32'h0);
    step(1'b0, 8'h12, 1'b0, 1'b0, 1'b0, "t2b");
    check("t2_dstd_const", 32'(DSTD), 32'h1234);
    check("t2_level_const", 32'(DSTD_LEVEL), 32'h1);
    pop1("t2pop");

    // 3: fill, overrun, drain in order
    for (int i = 0; i < 4; i++) push_word(seq[i], "t3push");
    check("t3_full_const", 32'(DSTD_FULL), 32'h1);
    push_word(16'h5555, "t3ovr");
    check("t3_overrun_const", 32'(DSTD_OVERRUN), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t3_order", 32'(DSTD), 32'(seq[i]));
      pop1("t3pop");
    end
    check("t3_empty_valid", 32'(DSTD_VALID), 32'h0);
    check("t3_sticky_ovr", 32'(DSTD_OVERRUN), 32'h1);

    // 4: full + completing load + pop
    for (int i = 0; i < 4; i++) push_word(seq[i], "t4push");
    step(1'b0, 8'h66, 1'b0, 1'b0, 1'b0, "t4a");
    step(1'b0, 8'h66, 1'b0, 1'b1, 1'b0, "t4b");
    check("t4_level_const", 32'(DSTD_LEVEL), 32'h4);
    check("t4_head_const", 32'(DSTD), 32'h2222);
    for (int i = 1; i < 4; i++) begin
      check("t4_order", 32'(DSTD), 32'(seq[i]));
      pop1("t4pop");
    end
    check("t4_last", 32'(DSTD), 32'h6666);
    pop1("t4pop");

    // 5: flush discards partial byte and overrun
    step(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, "t5a");
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, "t5flush");
    push_word(16'h5678, "t5push");
    check("t5_dstd_const", 32'(DSTD), 32'h5678);
    check("t5_ovr_const", 32'(DSTD_OVERRUN), 32'h0);

    // 6: empty-state DSTD and pop on empty
    pop1("t6pop");
    push_word(16'h4444, "t6push");
    pop1("t6pop");
`ifdef DSTD_HOLD_EN
    check("t6_idle_dstd", 32'(DSTD), 32'h4444);
`else
    check("t6_idle_dstd", 32'(DSTD), 32'h0000);
`endif
    pop1("t6empty");
    check("t6_level_const", 32'(DSTD_LEVEL), 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit ld_n = ($urandom_range(0, 99) >= 60);
      bit pp   = ($urandom_range(0, 99) < 40);
      bit fl   = ($urandom_range(0, 99) < 2);
      bit rs   = ($urandom_range(0, 199) < 1);
      step(ld_n, 8'($urandom), fl, pp, rs, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
